// File: rtl/wid_fifo_sched.sv
// W-data FIFO bank controller: tags a free FIFO per AW, routes W beats by WID,
// flushes on beat-count completion and grants drain in AW-acceptance order.
module wid_fifo_sched #(
  parameter int unsigned NUM_FIFO = 4,
  parameter int unsigned ID_W     = 11,
  parameter int unsigned LEN_W    = 8,
  localparam int unsigned IDX_W   = $clog2(NUM_FIFO)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aw_valid,
  output logic                     aw_ready,
  input  logic [ID_W-1:0]          aw_id,
  input  logic [LEN_W-1:0]         aw_len,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [ID_W-1:0]          w_id,
  input  logic                     w_last,
  output logic [NUM_FIFO-1:0]      fifo_push,
  input  logic [NUM_FIFO-1:0]      fifo_ready,
  output logic [NUM_FIFO-1:0]      fifo_flush,
  input  logic [NUM_FIFO-1:0]      fifo_flush_done,
  output logic [NUM_FIFO*ID_W-1:0] fifo_tag,
  output logic [NUM_FIFO-1:0]      drain_grant,
  output logic [IDX_W-1:0]         drain_idx,
  output logic                     busy,
  output logic                     len_err
);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2
  } slot_state_e;

  slot_state_e         state_q [NUM_FIFO];
  slot_state_e         state_d [NUM_FIFO];
  logic [ID_W-1:0]     tag_q   [NUM_FIFO];
  logic [ID_W-1:0]     tag_d   [NUM_FIFO];
  logic [LEN_W-1:0]    len_q   [NUM_FIFO];
  logic [LEN_W-1:0]    len_d   [NUM_FIFO];
  logic [LEN_W-1:0]    cnt_q   [NUM_FIFO];
  logic [LEN_W-1:0]    cnt_d   [NUM_FIFO];
  logic [IDX_W-1:0]    queue_q [NUM_FIFO];
  logic [IDX_W-1:0]    queue_d [NUM_FIFO];
  logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_FIFO-1:0] flush_d;
  logic                len_err_d;

  logic             free_any, id_block, hit_any;
  logic             aw_fire, w_fire, last_beat, head_ok, pop, done_err;
  logic [IDX_W-1:0] alloc_idx, hit_idx, head_slot;

  function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_FIFO - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  // Slot scan; descending order so the lowest free index wins.
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    id_block  = 1'b0;
    hit_any   = 1'b0;
    hit_idx   = '0;
    busy      = 1'b0;
    fifo_tag  = '0;
    for (int i = int'(NUM_FIFO) - 1; i >= 0; i--) begin
      fifo_tag[i*ID_W +: ID_W] = tag_q[i];
      if (state_q[i] != S_FREE) busy = 1'b1;
      if (state_q[i] == S_FREE) begin
        free_any  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
      if (state_q[i] == S_FILL && tag_q[i] == aw_id) id_block = 1'b1;
      if (state_q[i] == S_FILL && tag_q[i] == w_id) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign aw_ready    = free_any & ~id_block;
  assign aw_fire     = aw_valid & aw_ready;
  assign w_ready     = hit_any & fifo_ready[hit_idx];
  assign w_fire      = w_valid & w_ready;
  assign fifo_push   = (hit_any && w_valid) ? (NUM_FIFO'(1) << hit_idx) : '0;
  assign last_beat   = (cnt_q[hit_idx] == len_q[hit_idx]);
  assign head_slot   = queue_q[head_q];
  assign head_ok     = (count_q != '0) && (state_q[head_slot] == S_FLUSH);
  assign drain_grant = head_ok ? (NUM_FIFO'(1) << head_slot) : '0;
  assign drain_idx   = head_ok ? head_slot : '0;
  assign pop         = head_ok & fifo_flush_done[head_slot];
  // Any flush_done outside the currently granted slot is a protocol error.
  assign done_err    = |(fifo_flush_done & ~drain_grant);

  // Next-state for slots, order queue and flags.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    queue_d   = queue_q;
    head_d    = head_q;
    tail_d    = tail_q;
    flush_d   = '0;
    len_err_d = len_err;
    count_d   = count_q + CNT_W'(aw_fire) - CNT_W'(pop);
    if (aw_fire) begin
      state_d[alloc_idx] = S_FILL;
      tag_d[alloc_idx]   = aw_id;
      len_d[alloc_idx]   = aw_len;
      cnt_d[alloc_idx]   = '0;
      queue_d[tail_q]    = alloc_idx;
      tail_d             = ptr_inc(tail_q);
    end
    if (w_fire) begin
      if (last_beat) begin
        state_d[hit_idx] = S_FLUSH;
        flush_d[hit_idx] = 1'b1;
      end else begin
        cnt_d[hit_idx] = cnt_q[hit_idx] + LEN_W'(1);
      end
      if (w_last != last_beat) len_err_d = 1'b1;
    end
    if (pop) begin
      state_d[head_slot] = S_FREE;
      head_d             = ptr_inc(head_q);
    end
    if (done_err) len_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_FIFO); i++) begin
        state_q[i] <= S_FREE;
        tag_q[i]   <= '0;
        len_q[i]   <= '0;
        cnt_q[i]   <= '0;
        queue_q[i] <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fifo_flush <= '0;
      len_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      queue_q    <= queue_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fifo_flush <= flush_d;
      len_err    <= len_err_d;
    end
  end
endmodule
